// File: rtl/ascii_font_pkg.sv
// ascii_font_pkg: shared glyph geometry, glyph bitmaps and ASCII codes for the character-cell font
package ascii_font_pkg;

    localparam int ROWS_PER_CELL = 10;
    localparam int GLYPH_CNT     = 5;
    localparam int ROW_W         = $clog2(ROWS_PER_CELL);
    localparam int IDX_W         = $clog2(GLYPH_CNT);

    // Row 0 is the most significant byte so bitmaps read top-to-bottom in source
    typedef logic [0:ROWS_PER_CELL-1][7:0] glyph_t;

    // Every glyph has two blank rows above and below a six-row body
    function automatic glyph_t mk_glyph(input logic [47:0] body);
        return {16'h0000, body, 16'h0000};
    endfunction

    localparam glyph_t GLYPH_TAB [GLYPH_CNT] = '{
        mk_glyph(48'h7884_84FC_8484),
        mk_glyph(48'h8484_FC84_8484),
        mk_glyph(48'h0404_0484_8478),
        mk_glyph(48'h7884_8484_8478),
        mk_glyph(48'h0000_0000_0000)
    };

    localparam logic [7:0] CODE_TAB [GLYPH_CNT] = '{8'h41, 8'h48, 8'h4A, 8'h4F, 8'h20};

endpackage

// File: rtl/glyph_row_rom.sv
// glyph_row_rom: combinational lookup of one pixel row of one glyph
module glyph_row_rom
    import ascii_font_pkg::*;
(
    input  logic [IDX_W-1:0] glyph_idx,
    input  logic [ROW_W-1:0] row,
    output logic [7:0]       row_bits
);

    // Out-of-range glyph or row reads as a blank row
    always_comb begin
        row_bits = 8'h00;
        if (int'(glyph_idx) < GLYPH_CNT && int'(row) < ROWS_PER_CELL)
            row_bits = GLYPH_TAB[glyph_idx][row];
    end

endmodule

// File: rtl/pixel_to_ascii_decoder.sv
// pixel_to_ascii_decoder: identifies the ASCII glyph held in a streamed character cell
module pixel_to_ascii_decoder
    import ascii_font_pkg::*;
#(
    parameter logic [7:0] UNKNOWN_CODE = 8'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cell_start,
    input  logic       row_valid,
    output logic       row_ready,
    input  logic [7:0] pixel_row,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] ascii,
    output logic       matched
);

    localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(ROWS_PER_CELL - 1);
    localparam logic [GLYPH_CNT-1:0] ALL_ONES = '1;

    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic [GLYPH_CNT-1:0] mask_q, mask_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           ascii_q, ascii_d;
    logic                 matched_q, matched_d;
    logic [ROW_W-1:0]     eff_row;
    logic [7:0]           rom_row [GLYPH_CNT];
    logic [GLYPH_CNT-1:0] hit, mask_next;
    logic [7:0]           ascii_sel;
    logic                 last, accept, complete;

    // cell_start makes the incoming row row 0 regardless of the counter
    assign eff_row = cell_start ? '0 : row_cnt_q;

    for (genvar g = 0; g < GLYPH_CNT; g++) begin : g_rom
        glyph_row_rom u_rom (
            .glyph_idx (IDX_W'(g)),
            .row       (eff_row),
            .row_bits  (rom_row[g])
        );
        assign hit[g] = rom_row[g] == pixel_row;
    end

    assign last      = row_cnt_q == LAST_ROW;
    assign row_ready = !(last && out_valid_q && !out_ready);
    assign accept    = row_valid && row_ready;
    assign complete  = accept && !cell_start && last;
    assign mask_next = (cell_start ? ALL_ONES : mask_q) & hit;

    // Code of the surviving glyph; glyphs are distinct so at most one bit is set
    always_comb begin
        ascii_sel = UNKNOWN_CODE;
        for (int k = 0; k < GLYPH_CNT; k++)
            if (mask_next[k]) ascii_sel = CODE_TAB[k];
    end

    // Row counter, match mask and output register next state
    always_comb begin
        row_cnt_d   = row_cnt_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q && !out_ready;
        ascii_d     = ascii_q;
        matched_d   = matched_q;
        if (cell_start) begin
            row_cnt_d = accept ? ROW_W'(1) : '0;
            mask_d    = accept ? mask_next : ALL_ONES;
        end else if (accept) begin
            row_cnt_d = last ? '0 : row_cnt_q + 1'b1;
            mask_d    = last ? ALL_ONES : mask_next;
        end
        if (complete) begin
            out_valid_d = 1'b1;
            ascii_d     = ascii_sel;
            matched_d   = |mask_next;
        end
    end

    // State registers; reset discards any partial cell and pending result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_q   <= '0;
            mask_q      <= ALL_ONES;
            out_valid_q <= 1'b0;
            ascii_q     <= 8'h00;
            matched_q   <= 1'b0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            ascii_q     <= ascii_d;
            matched_q   <= matched_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ascii     = ascii_q;
    assign matched   = matched_q;

endmodule

// File: tb/tb_pixel_to_ascii_decoder.sv
// tb_pixel_to_ascii_decoder: directed checks of the glyph decoder
module tb_pixel_to_ascii_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cell_start = 1'b0;
    logic       row_valid = 1'b0;
    logic       row_ready;
    logic [7:0] pixel_row = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] ascii;
    logic       matched;

    int vecs = 0;
    int errs = 0;

    logic [7:0] a_rows [10] = '{8'h00, 8'h00, 8'h78, 8'h84, 8'h84, 8'hFC, 8'h84, 8'h84, 8'h00, 8'h00};
    logic [7:0] o_bad  [10] = '{8'h00, 8'h00, 8'h78, 8'h84, 8'h84, 8'h84, 8'h84, 8'h84, 8'h00, 8'h00};
    logic [7:0] h_rows [10] = '{8'h00, 8'h00, 8'h84, 8'h84, 8'hFC, 8'h84, 8'h84, 8'h84, 8'h00, 8'h00};
    logic [7:0] j_rows [10] = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h04, 8'h84, 8'h84, 8'h78, 8'h00, 8'h00};
    logic [7:0] junk   [4]  = '{8'h12, 8'h34, 8'h56, 8'h9A};

    pixel_to_ascii_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cell_start (cell_start),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .pixel_row  (pixel_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ascii      (ascii),
        .matched    (matched)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_row(input logic [7:0] d);
        row_valid = 1'b1;
        pixel_row = d;
        @(posedge clk);
        #1;
        row_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_matched", 8'(matched), 8'h00);
        chk("rst_row_ready", 8'(row_ready), 8'h01);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk("t1_no_early_valid", 8'(out_valid), 8'h00);
            send_row(a_rows[i]);
        end
        chk("t1_valid", 8'(out_valid), 8'h01);
        chk("t1_ascii", ascii, 8'h41);
        chk("t1_matched", 8'(matched), 8'h01);
        idle(1);
        chk("t1_drained", 8'(out_valid), 8'h00);
        chk("t1_ascii_hold", ascii, 8'h41);

        for (int i = 0; i < 10; i++) send_row(o_bad[i]);
        chk("t2_valid", 8'(out_valid), 8'h01);
        chk("t2_ascii", ascii, 8'h3F);
        chk("t2_matched", 8'(matched), 8'h00);
        idle(1);

        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send_row(h_rows[i]);
        chk("t3_h_valid", 8'(out_valid), 8'h01);
        chk("t3_h_ascii", ascii, 8'h48);
        for (int i = 0; i < 9; i++) send_row(j_rows[i]);
        chk("t3_h_held", ascii, 8'h48);
        row_valid = 1'b1;
        pixel_row = j_rows[9];
        #1;
        chk("t3_stall", 8'(row_ready), 8'h00);
        idle(2);
        chk("t3_stall_hold", 8'(row_ready), 8'h00);
        chk("t3_h_still", ascii, 8'h48);
        chk("t3_h_valid_still", 8'(out_valid), 8'h01);
        out_ready = 1'b1;
        #1;
        chk("t3_unstall", 8'(row_ready), 8'h01);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        chk("t3_j_valid", 8'(out_valid), 8'h01);
        chk("t3_j_ascii", ascii, 8'h4A);
        chk("t3_j_matched", 8'(matched), 8'h01);
        idle(1);
        chk("t3_j_drained", 8'(out_valid), 8'h00);

        for (int i = 0; i < 4; i++) send_row(junk[i]);
        cell_start = 1'b1;
        send_row(j_rows[0]);
        cell_start = 1'b0;
        for (int i = 1; i < 10; i++) send_row(j_rows[i]);
        chk("t4_valid", 8'(out_valid), 8'h01);
        chk("t4_ascii", ascii, 8'h4A);
        chk("t4_matched", 8'(matched), 8'h01);
        idle(1);

        for (int i = 0; i < 5; i++) send_row(a_rows[i]);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 8'(out_valid), 8'h00);
        chk("t5_rst_ascii", ascii, 8'h00);
        chk("t5_rst_matched", 8'(matched), 8'h00);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) send_row(8'h00);
        chk("t5_valid", 8'(out_valid), 8'h01);
        chk("t5_ascii", ascii, 8'h20);
        chk("t5_matched", 8'(matched), 8'h01);
        idle(1);

        for (int i = 0; i < 10; i++) begin
            send_row(a_rows[i]);
            if (i < 9) begin
                idle(1 + (i % 3));
                chk("t6_gap_no_valid", 8'(out_valid), 8'h00);
            end
        end
        chk("t6_valid", 8'(out_valid), 8'h01);
        chk("t6_ascii", ascii, 8'h41);
        chk("t6_matched", 8'(matched), 8'h01);
        idle(1);
        chk("t6_drained", 8'(out_valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
